// File: rtl/polarity_event_encoder.sv
// Polarity event encoder: round-robin arbitration of per-channel ON/OFF requests into an event FIFO.
// Optional macro POL_DROP_CNT_EN enables the saturating discarded-conflict counter on drop_cnt_o.
module polarity_event_encoder #(
  parameter int NUM_CH        = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int CONFLICT_MODE = 0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [2*NUM_CH-1:0]       req_i,
  output logic [NUM_CH-1:0]         ack_o,
  output logic                      evt_valid_o,
  input  logic                      evt_ready_i,
  output logic [$clog2(NUM_CH)-1:0] evt_ch_o,
  output logic                      evt_pol_o,
  output logic                      fifo_full_o,
  output logic [15:0]               drop_cnt_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_CH-1:0] elig_p0;
  logic [NUM_CH-1:0] ack_p1;
  logic [NUM_CH-1:0] last_pol;
  logic [CH_W-1:0]   rr_ptr;
  logic              grant_ok_p0;
  logic              gnt_vld_p0;
  logic [CH_W-1:0]   gnt_idx_p0;
  logic [1:0]        gnt_req_p0;
  logic              gnt_on_off_p0;
  logic              gnt_conflict_p0;
  logic              push_en_p0;
  logic              push_pol_p0;
  logic              pop_en;

  logic [CH_W:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic [CH_W:0]     head;

  // Stage p0: decode, eligibility and round-robin grant
  // A channel acked this cycle still shows its old request; masking it keeps one grant per request.
  always_comb begin
    elig_p0 = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig_p0[c] = (req_i[2*c+1] | req_i[2*c]) & ~ack_p1[c];
    end
  end

  assign pop_en      = evt_valid_o & evt_ready_i;
  assign grant_ok_p0 = ~fifo_full_o | pop_en;

  // Walk offsets high-to-low so the lowest offset from rr_ptr wins.
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    if (grant_ok_p0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (elig_p0[(int'(rr_ptr) + i) % NUM_CH]) begin
          gnt_vld_p0 = 1'b1;
          gnt_idx_p0 = CH_W'((int'(rr_ptr) + i) % NUM_CH);
        end
      end
    end
  end

  assign gnt_req_p0      = req_i[2*gnt_idx_p0 +: 2];
  assign gnt_on_off_p0   = gnt_req_p0[1] ^ gnt_req_p0[0];
  assign gnt_conflict_p0 = &gnt_req_p0;
  assign push_en_p0      = gnt_vld_p0 &&
                           (gnt_on_off_p0 || (CONFLICT_MODE != 0 && gnt_conflict_p0));
  assign push_pol_p0     = gnt_on_off_p0 ? gnt_req_p0[1] : last_pol[gnt_idx_p0];

  // Stage p1: arbiter state, acknowledge and FIFO control
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rr_ptr   <= '0;
      ack_p1   <= '0;
      last_pol <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      ack_p1 <= '0;
      if (gnt_vld_p0) begin
        ack_p1[gnt_idx_p0] <= 1'b1;
        rr_ptr <= (gnt_idx_p0 == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx_p0 + 1'b1;
        if (gnt_on_off_p0) begin
          last_pol[gnt_idx_p0] <= gnt_req_p0[1];
        end
      end
      if (push_en_p0) begin
        wptr <= wptr + 1'b1;
      end
      if (pop_en) begin
        rptr <= rptr + 1'b1;
      end
      case ({push_en_p0, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en_p0) begin
      mem[wptr] <= {gnt_idx_p0, push_pol_p0};
    end
  end

  assign head        = mem[rptr];
  assign ack_o       = ack_p1;
  assign evt_valid_o = (count != '0);
  assign fifo_full_o = (count == CNT_W'(FIFO_DEPTH));
  assign evt_ch_o    = evt_valid_o ? head[CH_W:1] : '0;
  assign evt_pol_o   = evt_valid_o ? head[0] : 1'b0;

`ifdef POL_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        discard_p0;
  logic [15:0] drop_cnt_p1;

  assign discard_p0 = gnt_vld_p0 && gnt_conflict_p0 && (CONFLICT_MODE == 0);

  // Stage p1: discarded-conflict counter
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      drop_cnt_p1 <= '0;
    end else if (discard_p0) begin
      drop_cnt_p1 <= sat_inc16(drop_cnt_p1);
    end
  end

  assign drop_cnt_o = drop_cnt_p1;
`else
  assign drop_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_polarity_event_encoder.sv
// Directed bench for polarity_event_encoder: one instance per conflict mode, sharing clock and reset.
module tb_polarity_event_encoder;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] req0, req1;
  logic       rdy0, rdy1;
  logic [3:0] ack0, ack1;
  logic       valid0, valid1, pol0, pol1, full0, full1;
  logic [1:0] ch0, ch1;
  logic [15:0] drop0, drop1;

  int checks = 0;
  int errors = 0;
  int acks;
  logic [15:0] exp_drop;

  always #5 clk_i = ~clk_i;

  polarity_event_encoder #(.NUM_CH(4), .FIFO_DEPTH(4), .CONFLICT_MODE(0)) dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req0), .ack_o(ack0),
    .evt_valid_o(valid0), .evt_ready_i(rdy0), .evt_ch_o(ch0), .evt_pol_o(pol0),
    .fifo_full_o(full0), .drop_cnt_o(drop0)
  );

  polarity_event_encoder #(.NUM_CH(4), .FIFO_DEPTH(4), .CONFLICT_MODE(1)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req1), .ack_o(ack1),
    .evt_valid_o(valid1), .evt_ready_i(rdy1), .evt_ch_o(ch1), .evt_pol_o(pol1),
    .fifo_full_o(full1), .drop_cnt_o(drop1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
`ifdef POL_DROP_CNT_EN
    exp_drop = 16'd1;
`else
    exp_drop = 16'd0;
`endif
    reset_i = 1'b0;
    req0 = '0; req1 = '0; rdy0 = 1'b0; rdy1 = 1'b0;
    #1;
    check("rst_valid", valid0, 0);
    check("rst_full", full0, 0);
    check("rst_ack", ack0, 0);
    check("rst_ch_pol", {ch0, pol0}, 0);
    check("rst_drop", drop0, 0);
    tick(); tick();
    reset_i = 1'b1;
    tick();
    check("post_rst_valid", {valid0, valid1}, 0);
    check("post_rst_ack", {ack0, ack1}, 0);

    // all four channels OFF at once: granted 0,1,2,3 one per cycle
    rdy0 = 1'b1;
    req0 = 8'b01_01_01_01;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rr_ack%0d", c), ack0, 4'b0001 << c);
      check($sformatf("rr_evt%0d", c), {valid0, ch0, pol0}, {1'b1, 2'(c), 1'b0});
      req0[2*c +: 2] = 2'b00;
    end
    tick();
    check("rr_done", {ack0, valid0}, 0);

    // single ON request on channel 1
    req0 = 8'b00_00_10_00;
    tick();
    check("on_ack", ack0, 4'b0010);
    check("on_evt", {valid0, ch0, pol0}, {1'b1, 2'd1, 1'b1});
    req0 = '0;
    tick();
    check("on_popped", {ack0, valid0}, 0);

    // fill with ready low, channel 0 alternating ON/OFF per ack
    rdy0 = 1'b0;
    req0 = 8'b00_00_00_10;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ack0[0]) begin
        acks++;
        req0[1:0] = ~req0[1:0];
      end
    end
    check("fill_acks", acks, 4);
    check("fill_full", full0, 1);
    check("fill_head", {valid0, ch0, pol0}, {1'b1, 2'd0, 1'b1});
    rdy0 = 1'b1;
    tick();
    rdy0 = 1'b0;
    check("full_pushpop_ack", ack0, 4'b0001);
    check("full_pushpop_full", full0, 1);
    check("full_pushpop_head", pol0, 0);
    req0 = '0;
    rdy0 = 1'b1;
    tick(); check("drain1", {valid0, pol0}, 2'b11);
    check("drain1_notfull", full0, 0);
    tick(); check("drain2", {valid0, pol0}, 2'b10);
    tick(); check("drain3", {valid0, pol0}, 2'b11);
    tick(); check("drain_empty", valid0, 0);

    // conflict on channel 2 in discard mode
    req0 = 8'b00_11_00_00;
    tick();
    check("cfl_ack", ack0, 4'b0100);
    check("cfl_noevt", valid0, 0);
    check("cfl_drop", drop0, exp_drop);
    req0 = '0;
    tick();
    check("cfl_after", {ack0, valid0}, 0);
    check("cfl_drop_hold", drop0, exp_drop);

    // conflict in last-polarity mode on channel 3
    req1 = 8'b10_00_00_00;
    tick();
    check("m1_ack_on", ack1, 4'b1000);
    check("m1_head", {valid1, ch1, pol1}, {1'b1, 2'd3, 1'b1});
    req1 = 8'b11_00_00_00;
    tick();
    check("m1_masked", ack1, 0);
    tick();
    check("m1_ack_cfl", ack1, 4'b1000);
    req1 = 8'b00_00_01_00;
    tick();
    check("m1_ack_ch1", ack1, 4'b0010);
    req1 = '0;
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    check("m1_second_evt", {valid1, ch1, pol1}, {1'b1, 2'd3, 1'b1});
    req1 = 8'b00_10_00_00;
    tick();
    check("m1_ack_ch2", ack1, 4'b0100);
    req1 = '0;

    // reset with three events buffered
    reset_i = 1'b0;
    #1;
    check("mid_rst_valid", {valid1, full1, ack1}, 0);
    check("mid_rst_head", {ch1, pol1}, 0);
    #2;
    reset_i = 1'b1;
    tick();
    check("after_rst_valid", valid1, 0);
    req1 = 8'b10_00_00_10;
    tick();
    check("rst_rr_ack", ack1, 4'b0001);
    check("rst_rr_head", {valid1, ch1, pol1}, {1'b1, 2'd0, 1'b1});
    req1 = 8'b11_00_00_00;
    rdy1 = 1'b1;
    tick();
    check("rst_lastpol_ack", ack1, 4'b1000);
    check("rst_lastpol_evt", {valid1, ch1, pol1}, {1'b1, 2'd3, 1'b0});
    req1 = '0;
    tick();
    check("final_empty", valid1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
